// File: rtl/pkg_coproc.sv
// Shared constants, state encoding and element indexing for the matrix-multiply coprocessor.
package pkg_coproc;

    localparam int DIM     = 5;
    localparam int LARG    = 8;
    localparam int TAM_MAX = DIM;
    localparam int LIN_W   = LARG * DIM;
    localparam int MAT_W   = LARG * DIM * DIM;

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        CONCLUI
    } estado_t;

    // Bit offset of element (l,c) in a flattened row-major matrix.
    function automatic int idx(input int l, input int c);
        return LARG * (c + DIM * l);
    endfunction

endpackage

// File: rtl/linha_produto.sv
// One result row: DIM signed dot products of an A row against the columns of B,
// truncated to LARG bits (wrap-around).
module linha_produto
    import pkg_coproc::*;
(
    input  logic [LIN_W-1:0] linha_a,
    input  logic [MAT_W-1:0] matriz_b,
    output logic [LIN_W-1:0] linha_r
);

    localparam int PROD_W = 2 * LARG;
    localparam int SOMA_W = 2 * LARG + 3;

    logic signed [PROD_W-1:0] prod;
    logic signed [SOMA_W-1:0] soma;

    always_comb begin
        linha_r = '0;
        prod    = '0;
        soma    = '0;
        for (int c = 0; c < DIM; c++) begin
            soma = '0;
            for (int j = 0; j < DIM; j++) begin
                prod = $signed(linha_a[LARG*j +: LARG]) * $signed(matriz_b[idx(j, c) +: LARG]);
                soma = soma + SOMA_W'(prod);
            end
            linha_r[LARG*c +: LARG] = soma[LARG-1:0];
        end
    end

endmodule

// File: rtl/controlador_mult_matriz.sv
// Sequencer for the row-at-a-time signed matrix multiply: latches masked operands,
// writes one result row per clock, then pulses pronto.
module controlador_mult_matriz
    import pkg_coproc::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic [2:0]       tamanho,
    input  logic [MAT_W-1:0] matriz_a,
    input  logic [MAT_W-1:0] matriz_b,
    output logic             ocupado,
    output logic             pronto,
    output logic             erro,
    output logic [MAT_W-1:0] matriz_result
);

    estado_t          estado_q;
    logic [2:0]       linha_q;
    logic [2:0]       n_q;
    logic [MAT_W-1:0] a_q;
    logic [MAT_W-1:0] b_q;
    logic [MAT_W-1:0] result_q;
    logic             ocupado_q;
    logic             pronto_q;
    logic             erro_q;

    logic [LIN_W-1:0] linha_sel;
    logic [LIN_W-1:0] linha_res;
    logic             tamanho_ok;

    // Zero every element outside the active N x N corner so the full-width datapath
    // leaves rows and columns >= N at zero.
    function automatic logic [MAT_W-1:0] mascara(input logic [MAT_W-1:0] m, input logic [2:0] n);
        logic [MAT_W-1:0] r;
        r = '0;
        for (int l = 0; l < DIM; l++)
            for (int c = 0; c < DIM; c++)
                if (l < int'(n) && c < int'(n))
                    r[idx(l, c) +: LARG] = m[idx(l, c) +: LARG];
        return r;
    endfunction

    assign tamanho_ok = (tamanho != 3'd0) && (int'(tamanho) <= TAM_MAX);

    always_comb begin
        linha_sel = '0;
        for (int l = 0; l < DIM; l++)
            if (linha_q == 3'(l))
                linha_sel = a_q[LIN_W*l +: LIN_W];
    end

    linha_produto u_linha_produto (
        .linha_a  (linha_sel),
        .matriz_b (b_q),
        .linha_r  (linha_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            linha_q   <= '0;
            n_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (inicio) begin
                        if (tamanho_ok) begin
                            a_q       <= mascara(matriz_a, tamanho);
                            b_q       <= mascara(matriz_b, tamanho);
                            n_q       <= tamanho;
                            result_q  <= '0;
                            linha_q   <= '0;
                            ocupado_q <= 1'b1;
                            estado_q  <= CALCULA;
                        end else begin
                            erro_q <= 1'b1;
                        end
                    end
                end
                CALCULA: begin
                    for (int l = 0; l < DIM; l++)
                        if (linha_q == 3'(l))
                            result_q[LIN_W*l +: LIN_W] <= linha_res;
                    if (linha_q == n_q - 3'd1)
                        estado_q <= CONCLUI;
                    else
                        linha_q <= linha_q + 3'd1;
                end
                CONCLUI: begin
                    pronto_q  <= 1'b1;
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign ocupado       = ocupado_q;
    assign pronto        = pronto_q;
    assign erro          = erro_q;
    assign matriz_result = result_q;

endmodule
